// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, control-state encodings and GF(2^8) multiply helpers
package aes_pkg;

    localparam logic       KEYLEN_128 = 1'h0;
    localparam logic       KEYLEN_256 = 1'h1;
    localparam logic [3:0] ROUNDS_128 = 4'ha;
    localparam logic [3:0] ROUNDS_256 = 4'he;

    typedef enum logic [2:0] {
        CTRL_IDLE = 3'h0,
        CTRL_INIT = 3'h1,
        CTRL_SBOX = 3'h2,
        CTRL_MAIN = 3'h3
    } aes_ctrl_t;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] b);
        return gm2(gm2(b));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] b);
        return gm2(gm4(b));
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return gm8(b) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm8(b) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ gm2(b);
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational inverse S-box applied to the four bytes of one word
module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    // Entry 0 sits in the top byte, so entry x lives at bit offset 8*(255-x) = {~x, 3'b000}.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] lookup(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    assign new_sword = {lookup(sword[31:24]), lookup(sword[23:16]),
                        lookup(sword[15:8]),  lookup(sword[7:0])};

endmodule

// File: rtl/aes_decipher_block.sv
// rtl/aes_decipher_block.sv - iterative AES-128/256 inverse cipher, one S-box word per cycle
module aes_decipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    logic [31:0]  w [4];
    logic [127:0] cur_block;
    logic [127:0] block_nxt;
    logic [3:0]   w_we;
    logic [3:0]   round_ctr, round_nxt;
    logic [1:0]   word_ctr, word_nxt;
    logic         ready_reg, ready_nxt;
    aes_ctrl_t    state, state_nxt;
    logic [31:0]  sbox_in, sbox_out;

    function automatic logic [31:0] inv_mixw(input logic [31:0] x);
        logic [7:0] b0, b1, b2, b3;
        b0 = x[31:24];
        b1 = x[23:16];
        b2 = x[15:8];
        b3 = x[7:0];
        return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
                gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
                gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
                gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] b);
        return {inv_mixw(b[127:96]), inv_mixw(b[95:64]), inv_mixw(b[63:32]), inv_mixw(b[31:0])};
    endfunction

    // Row r of each column comes from the column r positions to its left.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] b);
        logic [31:0] c0, c1, c2, c3;
        c0 = b[127:96];
        c1 = b[95:64];
        c2 = b[63:32];
        c3 = b[31:0];
        return {c0[31:24], c3[23:16], c2[15:8], c1[7:0],
                c1[31:24], c0[23:16], c3[15:8], c2[7:0],
                c2[31:24], c1[23:16], c0[15:8], c3[7:0],
                c3[31:24], c2[23:16], c1[15:8], c0[7:0]};
    endfunction

    assign cur_block = {w[0], w[1], w[2], w[3]};
    assign new_block = cur_block;
    assign round     = round_ctr;
    assign ready     = ready_reg;
    assign sbox_in   = w[word_ctr];

    aes_inv_sbox u_inv_sbox (
        .sword     (sbox_in),
        .new_sword (sbox_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                w[i] <= '0;
            end
            round_ctr <= '0;
            word_ctr  <= '0;
            ready_reg <= 1'b1;
            state     <= CTRL_IDLE;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_we[i]) begin
                    w[i] <= block_nxt[127 - 32*i -: 32];
                end
            end
            round_ctr <= round_nxt;
            word_ctr  <= word_nxt;
            ready_reg <= ready_nxt;
            state     <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        round_nxt = round_ctr;
        word_nxt  = word_ctr;
        ready_nxt = ready_reg;
        block_nxt = '0;
        w_we      = 4'b0000;

        unique case (state)
            CTRL_IDLE: begin
                if (next) begin
                    round_nxt = (keylen == KEYLEN_256) ? ROUNDS_256 : ROUNDS_128;
                    ready_nxt = 1'b0;
                    state_nxt = CTRL_INIT;
                end
            end
            CTRL_INIT: begin
                block_nxt = inv_shiftrows(block ^ round_key);
                w_we      = 4'b1111;
                round_nxt = round_ctr - 4'd1;
                word_nxt  = 2'd0;
                state_nxt = CTRL_SBOX;
            end
            CTRL_SBOX: begin
                // Every lane carries the S-box result; only the selected word is enabled.
                block_nxt          = {4{sbox_out}};
                w_we[word_ctr]     = 1'b1;
                word_nxt           = word_ctr + 2'd1;
                if (word_ctr == 2'd3) begin
                    state_nxt = CTRL_MAIN;
                end
            end
            CTRL_MAIN: begin
                word_nxt = 2'd0;
                w_we     = 4'b1111;
                if (round_ctr != 4'd0) begin
                    block_nxt = inv_shiftrows(inv_mixcolumns(cur_block ^ round_key));
                    round_nxt = round_ctr - 4'd1;
                    state_nxt = CTRL_SBOX;
                end else begin
                    block_nxt = cur_block ^ round_key;
                    ready_nxt = 1'b1;
                    state_nxt = CTRL_IDLE;
                end
            end
            default: begin
                state_nxt = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_decipher_block.sv
// tb/tb_aes_decipher_block.sv - scoreboard bench for aes_decipher_block with FIPS-197 vectors
module tb_aes_decipher_block;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk [16];

    typedef struct {
        logic [127:0] pt;
        int           nr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   results  = 0;
    int   idle_gap = 0;

    localparam int N_RAND = 300;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always #5 clk = ~clk;

    assign round_key = rk[round];

    aes_decipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    // Key memory contents: FIPS-197 key expansion for the selected key length.
    task automatic expand(input logic [255:0] key, input logic klen);
        logic [31:0] kw [64];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nw;
        nk = klen ? 8 : 4;
        nw = klen ? 60 : 44;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) kw[i] = '0;
        for (int i = 0; i < nk; i++) kw[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = kw[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            kw[i] = kw[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
    endtask

    // Forward cipher, used only to produce ciphertexts for the random round-trip.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        x = pt ^ rk[0];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb(x[127 - 8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[c*4+q] = s[((c+q)%4)*4+q];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[c*4+0] = xt(t[c*4]) ^ xt(t[c*4+1]) ^ t[c*4+1] ^ t[c*4+2] ^ t[c*4+3];
                    s[c*4+1] = t[c*4] ^ xt(t[c*4+1]) ^ xt(t[c*4+2]) ^ t[c*4+2] ^ t[c*4+3];
                    s[c*4+2] = t[c*4] ^ t[c*4+1] ^ xt(t[c*4+2]) ^ xt(t[c*4+3]) ^ t[c*4+3];
                    s[c*4+3] = xt(t[c*4]) ^ t[c*4] ^ t[c*4+1] ^ t[c*4+2] ^ xt(t[c*4+3]);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) x[127 - 8*i -: 8] = s[i];
            x = x ^ rk[r];
        end
        return x;
    endfunction

    task automatic issue(input logic [255:0] key, input logic klen,
                         input logic [127:0] ct, input logic [127:0] pt);
        exp_t e;
        @(negedge clk);
        expand(key, klen);
        block  = ct;
        keylen = klen;
        e.pt   = pt;
        e.nr   = klen ? 14 : 10;
        exp_q.push_back(e);
        next   = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > budget) begin
                chk("ready_timeout", 128'(n), 128'(budget));
                break;
            end
        end
    endtask

    // Monitor: per-cycle round sequence, completion latency, result and hold checks.
    initial begin : monitor
        int           busy;
        int           idle_cnt;
        logic         prev_ready;
        logic         have;
        logic [127:0] held;
        exp_t         e;
        busy       = 0;
        idle_cnt   = 100;
        prev_ready = 1'b1;
        have       = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy       = 0;
                idle_cnt   = 100;
                prev_ready = 1'b1;
                have       = 1'b0;
            end else begin
                if (!ready) begin
                    if (prev_ready) idle_gap = idle_cnt;
                    idle_cnt = 0;
                    busy++;
                    if (exp_q.size() > 0 && (busy - 1) % 5 == 0)
                        chk("round_seq", 128'(round), 128'(exp_q[0].nr - (busy - 1) / 5));
                end else begin
                    if (!prev_ready) begin
                        results++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 128'(1), 128'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("plaintext", new_block, e.pt);
                            chk("latency", 128'(busy), 128'(1 + 5 * e.nr));
                        end
                        held = new_block;
                        have = 1'b1;
                        busy = 0;
                    end else if (have) begin
                        chk("hold", new_block, held);
                    end
                    idle_cnt++;
                end
                prev_ready = ready;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : driver
        int           r0;
        logic [255:0] key;
        logic         klen;
        logic [127:0] pt;
        logic [127:0] ct;

        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 128'(ready), 128'(1));
        chk("reset_block", new_block, 128'h0);
        chk("reset_round", 128'(round), 128'(0));
        reset_n = 1'b1;

        // FIPS-197 C.1 and C.3
        issue(K128, 1'b0, CT128, PT);
        @(posedge clk); #1 next = 1'b0;
        wait_ready(100);
        issue(K256, 1'b1, CT256, PT);
        @(posedge clk); #1 next = 1'b0;
        wait_ready(100);

        // next held for the whole run, keylen wiggled after accept
        r0 = results;
        issue(K128, 1'b0, CT128, PT);
        repeat (7) @(negedge clk);
        keylen = 1'b1;
        repeat (13) @(negedge clk);
        keylen = 1'b0;
        repeat (5) @(negedge clk);
        keylen = 1'b1;
        wait_ready(100);
        next = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_one_result", 128'(results - r0), 128'(1));
        chk("busy_idle", 128'(ready), 128'(1));

        // Reset at cycle 20 of an AES-128 run
        issue(K128, 1'b0, CT128, PT);
        @(posedge clk); #1 next = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_reset_busy", 128'(ready), 128'(0));
        reset_n = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        #1;
        chk("abort_ready", 128'(ready), 128'(1));
        chk("abort_block", new_block, 128'h0);
        chk("abort_round", 128'(round), 128'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(K128, 1'b0, CT128, PT);
        @(posedge clk); #1 next = 1'b0;
        wait_ready(100);

        // Back-to-back: next stays high across the ready rising edge
        issue(K128, 1'b0, CT128, PT);
        wait_ready(100);
        expand(K256, 1'b1);
        block  = CT256;
        keylen = 1'b1;
        exp_q.push_back('{pt: PT, nr: 14});
        @(posedge clk); #1 next = 1'b0;
        wait_ready(100);
        chk("b2b_gap", 128'(idle_gap), 128'(1));

        // Random round-trip against the forward cipher
        for (int k = 0; k < N_RAND; k++) begin
            key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            klen = 1'($urandom_range(0, 1));
            pt   = {$urandom, $urandom, $urandom, $urandom};
            expand(key, klen);
            ct = encrypt(pt, klen ? 14 : 10);
            issue(key, klen, ct, pt);
            @(posedge clk); #1 next = 1'b0;
            wait_ready(100);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
